// File: rtl/evrisim_denetleyici_if.sv
// Handshake bundle between the frame controller, the pixel source/result sink
// and the convolution unit.
interface evrisim_denetleyici_if;
    logic        baslat_i;
    logic        iptal_i;
    logic [71:0] filtre_cfg_i;
    logic        piksel_gecerli_i;
    logic [7:0]  piksel_i;
    logic        piksel_hazir_o;
    logic        eb_filtre_etkin_o;
    logic [71:0] eb_filtre_o;
    logic        eb_veri_etkin_o;
    logic [7:0]  eb_veri_o;
    logic        eb_veri_etkin_i;
    logic [7:0]  eb_veri_i;
    logic        sonuc_gecerli_o;
    logic [7:0]  sonuc_o;
    logic        mesgul_o;
    logic        bitti_o;
    logic        hata_o;

    modport slave (
        input  baslat_i, iptal_i, filtre_cfg_i, piksel_gecerli_i, piksel_i,
               eb_veri_etkin_i, eb_veri_i,
        output piksel_hazir_o, eb_filtre_etkin_o, eb_filtre_o, eb_veri_etkin_o,
               eb_veri_o, sonuc_gecerli_o, sonuc_o, mesgul_o, bitti_o, hata_o
    );

    modport master (
        output baslat_i, iptal_i, filtre_cfg_i, piksel_gecerli_i, piksel_i,
               eb_veri_etkin_i, eb_veri_i,
        input  piksel_hazir_o, eb_filtre_etkin_o, eb_filtre_o, eb_veri_etkin_o,
               eb_veri_o, sonuc_gecerli_o, sonuc_o, mesgul_o, bitti_o, hata_o
    );
endinterface

// File: rtl/evrisim_denetleyici.sv
// Frame controller for a 3x3 convolution unit: loads the filter, streams one
// frame of pixels into the unit and drains its results with a timeout.
module evrisim_denetleyici #(
    parameter int GENISLIK    = 320,
    parameter int YUKSEKLIK   = 240,
    parameter int ZAMAN_ASIMI = 1024
) (
    input logic                  clk_i,
    input logic                  rstn_i,
    evrisim_denetleyici_if.slave bus
);
    localparam int TOPLAM  = GENISLIK * YUKSEKLIK;
    localparam int SUTUN_W = (GENISLIK > 1) ? $clog2(GENISLIK) : 1;
    localparam int SATIR_W = (YUKSEKLIK > 1) ? $clog2(YUKSEKLIK) : 1;
    localparam int SONUC_W = $clog2(TOPLAM + 1);
    localparam int BOSALT_W = $clog2(ZAMAN_ASIMI + 1);

    typedef enum logic [2:0] {BOSTA, FILTRE, AKIS, BOSALT, BITTI} durum_t;
    durum_t durum, durum_sonraki;

    logic [SUTUN_W-1:0]  sutun;
    logic [SATIR_W-1:0]  satir;
    logic [SONUC_W-1:0]  sonuc_say;
    logic [BOSALT_W-1:0] bosalt_say;
    logic [71:0]         filtre;
    logic                veri_etkin;
    logic [7:0]          veri;
    logic                sonuc_gecerli;
    logic [7:0]          sonuc;
    logic                hata;

    logic               kabul, calisiyor, basla_ok, son_piksel, tamam, zaman_doldu;
    logic [SONUC_W:0]   sonuc_say_sonraki;

    always_comb begin
        kabul       = bus.piksel_gecerli_i && (durum == AKIS);
        calisiyor   = (durum == FILTRE) || (durum == AKIS) || (durum == BOSALT);
        basla_ok    = (durum == BOSTA) && bus.baslat_i && !bus.iptal_i;
        son_piksel  = kabul && (sutun == SUTUN_W'(GENISLIK - 1))
                            && (satir == SATIR_W'(YUKSEKLIK - 1));
        // A result arriving in the same cycle still counts toward completion
        sonuc_say_sonraki = {1'b0, sonuc_say}
                          + (SONUC_W + 1)'(calisiyor && bus.eb_veri_etkin_i);
        tamam       = sonuc_say_sonraki == (SONUC_W + 1)'(TOPLAM);
        zaman_doldu = bosalt_say == BOSALT_W'(ZAMAN_ASIMI - 1);

        durum_sonraki = durum;
        case (durum)
            BOSTA:   if (basla_ok) durum_sonraki = FILTRE;
            FILTRE:  durum_sonraki = AKIS;
            AKIS:    if (son_piksel) durum_sonraki = BOSALT;
            BOSALT:  if (tamam || zaman_doldu) durum_sonraki = BITTI;
            BITTI:   durum_sonraki = BOSTA;
            default: durum_sonraki = BOSTA;
        endcase
        if (bus.iptal_i) durum_sonraki = BOSTA;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) durum <= BOSTA;
        else         durum <= durum_sonraki;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sutun         <= '0;
            satir         <= '0;
            sonuc_say     <= '0;
            bosalt_say    <= '0;
            filtre        <= '0;
            veri_etkin    <= 1'b0;
            veri          <= '0;
            sonuc_gecerli <= 1'b0;
            sonuc         <= '0;
            hata          <= 1'b0;
        end else begin
            if (basla_ok || bus.iptal_i) begin
                sutun     <= '0;
                satir     <= '0;
                sonuc_say <= '0;
            end else begin
                if (kabul) begin
                    if (sutun == SUTUN_W'(GENISLIK - 1)) begin
                        sutun <= '0;
                        satir <= (satir == SATIR_W'(YUKSEKLIK - 1)) ? '0 : satir + SATIR_W'(1);
                    end else begin
                        sutun <= sutun + SUTUN_W'(1);
                    end
                end
                sonuc_say <= sonuc_say_sonraki[SONUC_W-1:0];
            end
            bosalt_say <= (durum == BOSALT && !bus.iptal_i) ? bosalt_say + BOSALT_W'(1) : '0;

            if (basla_ok) filtre <= bus.filtre_cfg_i;
            veri_etkin <= kabul && !bus.iptal_i;
            if (kabul) veri <= bus.piksel_i;

            // Results outside an active frame, or racing an abort, are dropped
            sonuc_gecerli <= calisiyor && bus.eb_veri_etkin_i && !bus.iptal_i;
            if (calisiyor) sonuc <= bus.eb_veri_i;

            if (basla_ok)
                hata <= 1'b0;
            else if (!bus.iptal_i && ((bus.baslat_i && durum != BOSTA) ||
                                      (durum == BOSALT && zaman_doldu && !tamam)))
                hata <= 1'b1;
        end
    end

    assign bus.piksel_hazir_o    = (durum == AKIS);
    assign bus.eb_filtre_etkin_o = (durum == FILTRE);
    assign bus.eb_filtre_o       = filtre;
    assign bus.eb_veri_etkin_o   = veri_etkin;
    assign bus.eb_veri_o         = veri;
    assign bus.sonuc_gecerli_o   = sonuc_gecerli;
    assign bus.sonuc_o           = sonuc;
    assign bus.mesgul_o          = (durum != BOSTA);
    assign bus.bitti_o           = (durum == BITTI);
    assign bus.hata_o            = hata;
endmodule

// File: doc/evrisim_denetleyici.md
EVRISIM_DENETLEYICI -- requirements
Module: evrisim_denetleyici

Interface
REQ-001 Parameter GENISLIK, default 320, frame width in pixels (columns).
REQ-002 Parameter YUKSEKLIK, default 240, frame height in pixels (rows).
REQ-003 Parameter ZAMAN_ASIMI, default 1024, maximum drain cycles before a timeout error.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: clk_i  input  1  clock, all state on rising edge; rstn_i  input  1  asynchronous active-low reset.
REQ-005 The block SHALL provide these ports:
- baslat_i  input  1  start-of-frame request pulse.
- iptal_i  input  1  synchronous abort.
- filtre_cfg_i  input  72  nine signed 8-bit 3x3 coefficients, [71:64]=k0 ... [7:0]=k8.
- piksel_gecerli_i  input  1  upstream pixel valid.
- piksel_i  input  8  upstream pixel.
- piksel_hazir_o  output  1  upstream ready.
- eb_filtre_etkin_o  output  1  filter-load strobe to the convolution unit.
- eb_filtre_o  output  72  filter to the convolution unit.
- eb_veri_etkin_o  output  1  pixel valid to the convolution unit.
- eb_veri_o  output  8  pixel to the convolution unit.
- eb_veri_etkin_i  input  1  result valid from the convolution unit.
- eb_veri_i  input  8  result from the convolution unit.
- sonuc_gecerli_o  output  1  forwarded result valid.
- sonuc_o  output  8  forwarded result.
- mesgul_o  output  1  frame in progress.
- bitti_o  output  1  one-cycle frame-done pulse.
- hata_o  output  1  sticky error flag.

Function
REQ-006 The FSM SHALL use states BOSTA, FILTRE, AKIS, BOSALT and BITTI; mesgul_o=1 in every state except BOSTA.
REQ-007 In BOSTA, when baslat_i=1 and iptal_i=0, the block SHALL latch filtre_cfg_i into eb_filtre_o, clear all counters and go to FILTRE.
REQ-008 In FILTRE, the block SHALL drive eb_filtre_etkin_o=1 for exactly one cycle, then go to AKIS; eb_filtre_etkin_o=0 at all other times.
REQ-009 In AKIS, piksel_hazir_o SHALL be 1; piksel_hazir_o SHALL be 0 in every other state.
REQ-010 Each accepted pixel (piksel_gecerli_i & piksel_hazir_o) SHALL appear on eb_veri_o with eb_veri_etkin_o=1 exactly one cycle later; eb_veri_etkin_o SHALL be 0 otherwise.
REQ-011 Column counter (0..GENISLIK-1) SHALL increment per accepted pixel and wrap to 0 with a row increment; row counter SHALL run 0..YUKSEKLIK-1.
REQ-012 Acceptance of pixel (row YUKSEKLIK-1, column GENISLIK-1) SHALL move the FSM to BOSALT; piksel_hazir_o SHALL be 0 from the next cycle.
REQ-013 Upstream gaps (piksel_gecerli_i=0) SHALL stall the counters with no effect on other state.
REQ-014 Result counter (width ceil(log2(GENISLIK*YUKSEKLIK+1))) SHALL count eb_veri_etkin_i pulses in FILTRE, AKIS and BOSALT only.
REQ-015 In FILTRE, AKIS and BOSALT, sonuc_gecerli_o/sonuc_o SHALL register eb_veri_etkin_i/eb_veri_i with one-cycle latency; in BOSTA and BITTI, sonuc_gecerli_o SHALL be 0 and unit outputs are dropped.
REQ-016 In BOSALT, the FSM SHALL go to BITTI when the result count equals GENISLIK*YUKSEKLIK, including a pulse counted in the same cycle.
REQ-017 A BOSALT cycle counter SHALL set hata_o=1 and force BITTI after ZAMAN_ASIMI cycles without completion.
REQ-018 BITTI SHALL last one cycle with bitti_o=1, then return to BOSTA.
REQ-019 baslat_i while mesgul_o=1 SHALL be ignored and SHALL set hata_o=1.
REQ-020 iptal_i=1 in any state SHALL return to BOSTA next cycle: counters cleared, eb_veri_etkin_o=0, no bitti_o, hata_o unchanged; iptal_i wins over a simultaneous baslat_i.
REQ-021 hata_o SHALL be cleared only by reset or by an accepted baslat_i.

Reset
REQ-022 With rstn_i=0, the block SHALL immediately enter BOSTA with all counters 0, and SHALL drive eb_filtre_o=0, eb_veri_o=0, sonuc_o=0 and every 1-bit output=0.
REQ-023 Reset deassertion SHALL be sampled on clk_i; the first baslat_i SHALL be honoured on the first rising edge with rstn_i=1.

Verification
REQ-024 GENISLIK=4, YUKSEKLIK=3: baslat_i with a Sobel-X filter, then 12 back-to-back pixels 0x00..0x0B -> one eb_filtre_etkin_o pulse carrying the filter, eb_veri_o=0x00..0x0B each delayed one cycle, piksel_hazir_o falls after the 12th pixel.
REQ-025 Same setup, with the model returning 12 results -> sonuc_o equals the model values at +1 cycle, then a single bitti_o pulse and mesgul_o=0.
REQ-026 Pixels with valid toggling 1,0,0,1 -> still exactly 12 eb_veri_etkin_o pulses, with the column wrap at 4 and the row wrap at 3.
REQ-027 Model returns only 11 results, ZAMAN_ASIMI=16 -> bitti_o 16 cycles into BOSALT, with hata_o=1 and remaining 1 until the next baslat_i.
REQ-028 iptal_i after pixel 5 together with baslat_i -> BOSTA, no bitti_o; a later baslat_i runs a clean 12-pixel frame.
REQ-029 rstn_i low mid-AKIS -> all outputs 0 asynchronously; a subsequent frame completes normally.
